// File: rtl/srl_fifo_ctrl.sv
// Shift-register FIFO with occupancy count, registered full/empty/almost-full flags.
// Optional registered output stage enabled by defining SRL_FIFO_CTRL_OREG_EN.
module srl_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   num_data_valid,
    output logic                  almost_full
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         srl_cnt_q, srl_cnt_d;
    logic [CW-1:0]         cnt_m1;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr, rd, srl_pop;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  af_q, af_d;
    logic [CW-1:0]         count_d;

    assign wr = if_write_ce & if_write & full_n_q;
    assign rd = if_read_ce & if_read & empty_n_q;

    // Oldest entry sits at count-1; clamp at empty so the index stays inside the array.
    assign cnt_m1 = srl_cnt_q - CW'(1);
    assign addr   = (srl_cnt_q == '0) ? '0 : cnt_m1[ADDR_WIDTH-1:0];

`ifdef SRL_FIFO_CTRL_OREG_EN
    logic [DATA_WIDTH-1:0] dout_q;
    logic [CW-1:0]         count_q;

    // Refill the output register whenever it is free or being drained.
    assign srl_pop        = (srl_cnt_q != '0) & (~empty_n_q | rd);
    assign if_dout        = dout_q;
    assign num_data_valid = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q  <= '0;
            count_q <= '0;
        end else begin
            if (srl_pop) dout_q <= mem[addr];
            count_q <= count_d;
        end
    end
`else
    assign srl_pop        = rd;
    assign if_dout        = mem[addr];
    assign num_data_valid = srl_cnt_q;
`endif

    always_comb begin
        srl_cnt_d = srl_cnt_q;
        case ({wr, srl_pop})
            2'b10:   srl_cnt_d = srl_cnt_q + CW'(1);
            2'b01:   srl_cnt_d = srl_cnt_q - CW'(1);
            default: srl_cnt_d = srl_cnt_q;
        endcase
`ifdef SRL_FIFO_CTRL_OREG_EN
        empty_n_d = srl_pop | (empty_n_q & ~rd);
        count_d   = srl_cnt_d + CW'(empty_n_d);
`else
        empty_n_d = (srl_cnt_d != '0);
        count_d   = srl_cnt_d;
`endif
        full_n_d = (srl_cnt_d != DepthC);
        af_d     = (count_d >= AfC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srl_cnt_q <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            af_q      <= 1'b0;
        end else begin
            srl_cnt_q <= srl_cnt_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            af_q      <= af_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= if_din;
        end
    end

    assign if_empty_n  = empty_n_q;
    assign if_full_n   = full_n_q;
    assign almost_full = af_q;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Self-checking bench for srl_fifo_ctrl: directed test-plan steps plus random traffic
// checked against a queue-based reference model (handles SRL_FIFO_CTRL_OREG_EN too).
module tb_srl_fifo_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int AF = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce, if_write, if_read_ce, if_read;
    logic [DW-1:0] if_din;
    logic [DW-1:0] if_dout;
    logic          if_full_n, if_empty_n, almost_full;
    logic [AW:0]   num_data_valid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: SRL contents as a queue, plus an optional output slot.
    logic [DW-1:0] q[$];
    logic          ov;
    logic [DW-1:0] od;

    srl_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .AF_THRESH (AF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_write_ce   (if_write_ce),
        .if_write      (if_write),
        .if_din        (if_din),
        .if_full_n     (if_full_n),
        .if_read_ce    (if_read_ce),
        .if_read       (if_read),
        .if_dout       (if_dout),
        .if_empty_n    (if_empty_n),
        .num_data_valid(num_data_valid),
        .almost_full   (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef SRL_FIFO_CTRL_OREG_EN
    function automatic int occ();
        return q.size() + (ov ? 1 : 0);
    endfunction
    function automatic logic m_empty_n();
        return ov;
    endfunction
    function automatic logic [DW-1:0] m_head();
        return od;
    endfunction
`else
    function automatic int occ();
        return q.size();
    endfunction
    function automatic logic m_empty_n();
        return q.size() != 0;
    endfunction
    function automatic logic [DW-1:0] m_head();
        return q[0];
    endfunction
`endif

    task automatic check_all(input string tag);
        chk({tag, ".empty_n"}, 32'(if_empty_n), 32'(m_empty_n()));
        chk({tag, ".full_n"}, 32'(if_full_n), 32'(q.size() != DEPTH));
        chk({tag, ".count"}, 32'(num_data_valid), 32'(occ()));
        chk({tag, ".af"}, 32'(almost_full), 32'(occ() >= AF));
        if (m_empty_n()) chk({tag, ".dout"}, 32'(if_dout), 32'(m_head()));
    endtask

    task automatic model_reset();
        q.delete();
        ov = 1'b0;
        od = '0;
    endtask

    // One clock: drive request, advance the model with what should be accepted, then compare.
    task automatic step(input string tag, input logic wce, input logic w, input logic [DW-1:0] d,
                        input logic rce, input logic r);
        logic acc_wr, acc_rd, pop;
        if_write_ce = wce;
        if_write    = w;
        if_din      = d;
        if_read_ce  = rce;
        if_read     = r;
        acc_wr = wce & w & (q.size() != DEPTH);
        acc_rd = rce & r & m_empty_n();
        @(posedge clk);
        #1;
`ifdef SRL_FIFO_CTRL_OREG_EN
        pop = (q.size() != 0) & (~ov | acc_rd);
        if (pop) begin
            od = q.pop_front();
            ov = 1'b1;
        end else if (acc_rd) begin
            ov = 1'b0;
        end
`else
        pop = acc_rd;
        if (pop) void'(q.pop_front());
`endif
        if (acc_wr) q.push_back(d);
        if_write_ce = 1'b0;
        if_write    = 1'b0;
        if_read_ce  = 1'b0;
        if_read     = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] v;
        int pw, pr;
        reset = 1'b1;
        if_write_ce = 1'b0;
        if_write = 1'b0;
        if_read_ce = 1'b0;
        if_read = 1'b0;
        if_din = '0;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;

        // Fill 0x01..0x10, then drain everything in order.
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
        step("fill_extra", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i <= DEPTH + 1; i++) step("drain", 1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("drained.empty_n", 32'(if_empty_n), 32'd0);

        // Single write latency.
        step("wr_a5", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        step("idle_a5", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step("idle_a5b", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("a5.dout", 32'(if_dout), 32'hA5);
        step("pop_a5", 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Hold five entries and stream wr+rd through for 20 cycles.
        for (int i = 0; i < 5; i++) step("hold_fill", 1'b1, 1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        step("hold_settle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 1'b1, DW'(8'h50 + i), 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step("stream_drain", 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // At full: write ignored, then wr+rd accepts only the read.
        for (int i = 0; i <= DEPTH; i++) step("fill2", 1'b1, 1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
        step("full_wr_ff", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        step("full_wrrd", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i <= DEPTH + 1; i++) step("drain2", 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // At empty: read ignored, wr+rd accepts only the write.
        step("empty_rd", 1'b0, 1'b0, '0, 1'b1, 1'b1);
        step("empty_wrrd", 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        step("empty_wrrd_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("3c.dout", 32'(if_dout), 32'h3C);

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst.empty_n", 32'(if_empty_n), 32'd0);
        chk("async_rst.full_n", 32'(if_full_n), 32'd1);
        chk("async_rst.count", 32'(num_data_valid), 32'd0);
        chk("async_rst.af", 32'(almost_full), 32'd0);
        #1 reset = 1'b0;
        step("post_rst_wr", 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step("post_rst_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("post_rst.dout", 32'(if_dout), 32'h11);
        step("post_rst_rd", 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Random traffic with phases biased toward filling, draining and balance.
        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 4 == 0) ? 85 : (ph % 4 == 1) ? 20 : (ph % 4 == 2) ? 55 : 95;
            pr = (ph % 4 == 0) ? 30 : (ph % 4 == 1) ? 85 : (ph % 4 == 2) ? 55 : 95;
            for (int c = 0; c < 250; c++) begin
                v = DW'($urandom);
                step("rand",
                     1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 99) < pw), v,
                     1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 99) < pr));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
